tdm_demux_rx: RTL and testbench
===============================

// Module: tdm_demux_rx
// PURPOSE
//  Receive end of the 4:1 select-mux path: recovers a time-division-multiplexed serial bit stream
//  (one bit per channel per frame, slot 0 marked by frame_sync) back into a parallel channel word.
//  Tracks slot position, detects framing errors, presents complete frames on a valid/ready output.
//  Sits between the serial link input stage and the per-channel consumers.
// PARAMETERS
//  CHANNELS  4   number of TDM slots per frame (>=2)
//  SEL_W     2   slot index width, = clog2(CHANNELS)
//  ERR_W     8   width of saturating framing-error counter
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  din         in   1         serial TDM data bit
//  din_valid   in   1         din (and frame_sync) sampled only when 1
//  frame_sync  in   1         qualifies din as slot 0 of a frame
//  sel         out  SEL_W     slot index the next accepted bit will occupy
//  dout        out  CHANNELS  recovered frame; bit i = slot i
//  dout_valid  out  1         dout holds an unconsumed frame
//  out_ready   in   1         consumer accepts dout when dout_valid&&out_ready
//  locked      out  1         1 in RUN state
//  sync_err    out  1         1-cycle pulse: frame_sync seen at slot != 0
//  overrun     out  1         1-cycle pulse: unconsumed frame overwritten
//  err_cnt     out  ERR_W     saturating count of sync_err events
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=HUNT, sel=0, dout=0, dout_valid=0, locked=0,
//   sync_err=0, overrun=0, err_cnt=0, shift/partial register=0. Reset mid-frame discards partial frame.
//  Beat = cycle with din_valid=1; no beat -> no state change (except output handshake).
//  FSM HUNT: beats without frame_sync ignored. Beat with frame_sync -> store din in slot 0, sel=1, go RUN.
//  FSM RUN (locked=1): each beat stores din at slot sel, sel increments mod CHANNELS.
//   - frame_sync on beat with sel==0: normal, accepted.
//   - frame_sync on beat with sel!=0: sync_err pulse next cycle, err_cnt+1 (saturates at all-ones),
//     partial frame discarded, din stored as slot 0, sel=1, stay RUN (no return to HUNT).
//   - beat at sel==CHANNELS-1 without frame_sync: frame complete; sel wraps to 0.
//  Frame complete: dout<=assembled frame and dout_valid<=1 on the following clock edge
//   (latency: 1 cycle after last-slot beat). Frame bits never change dout before completion.
//  Output handshake: dout_valid&&out_ready clears dout_valid next edge, unless a frame completes
//   the same cycle -> new frame loaded, dout_valid stays 1, no overrun.
//  Completion while dout_valid=1 and out_ready=0 -> dout overwritten by new frame, overrun pulse.
//  sel is registered and always reflects the current slot counter (0 in HUNT).
//  CHANNELS need not be a power of two: wrap is explicit compare to CHANNELS-1, not overflow.
// STRUCTURE
//  Shared package tdm_pkg: state enum {HUNT, RUN}, default CHANNELS/SEL_W constants, shared with the TX mux sequencer.
//  One sub-module: sat_counter (width ERR_W, inc, async active-low clear) for err_cnt.
//  Remainder flat: slot counter, frame assembly register, output holding register, FSM.
// TESTING
//  1. Reset, then beats with frame_sync on slot 0, bits 1,0,1,1 -> one cycle after 4th beat dout=4'b1101,
//     dout_valid=1, locked=1, sel=0.
//  2. In HUNT, 3 beats without frame_sync -> sel=0, locked=0, dout_valid=0; 4th beat with sync -> sel=1.
//  3. RUN, frame_sync on slot 2 -> sync_err 1-cycle pulse, err_cnt=1, sel=1, no dout update; next full frame correct.
//  4. out_ready=0 across two full frames -> overrun pulse once, dout = 2nd frame; out_ready=1 -> dout_valid=0 next cycle.
//  5. out_ready=1 in same cycle as completion with dout_valid=1 -> new dout, dout_valid stays 1, overrun=0.
//  6. Assert rst_n=0 after slot 1 -> all outputs 0 asynchronously; 260 sync errors -> err_cnt holds 8'hFF.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions used by the receive demux and the transmit mux sequencer.
package tdm_pkg;

  // Default frame geometry and error counter width.
  localparam int unsigned TDM_CHANNELS = 4;
  localparam int unsigned TDM_SEL_W    = $clog2(TDM_CHANNELS);
  localparam int unsigned TDM_ERR_W    = 8;

  // Framing state: HUNT waits for the first frame_sync, RUN tracks slots.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_rx_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold unless incrementing below the saturation value.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receive demux: rebuilds a parallel channel word from a serial stream
// carrying one bit per slot, with slot 0 marked by frame_sync.
//
// Output handshake (valid/ready): dout_valid rises when a frame completes and
// stays high, with dout stable, until a cycle where dout_valid && out_ready;
// the frame is consumed on that edge. A frame completing on that same edge
// replaces it and keeps dout_valid high. A frame completing while the held
// frame is still unconsumed (out_ready low) overwrites it and pulses overrun.
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNELS = TDM_CHANNELS,
  parameter int unsigned SEL_W    = TDM_SEL_W,
  parameter int unsigned ERR_W    = TDM_ERR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                din_valid,
  input  logic                frame_sync,
  output logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] dout,
  output logic                dout_valid,
  input  logic                out_ready,
  output logic                locked,
  output logic                sync_err,
  output logic                overrun,
  output logic [ERR_W-1:0]    err_cnt
);

  // Last slot index; wrap is an explicit compare so CHANNELS may be any value >= 2.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);

  tdm_state_e          state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CHANNELS-1:0] frame_q, frame_d;
  logic [CHANNELS-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sync_err_q, sync_err_d;
  logic                overrun_q, overrun_d;
  logic                err_inc;
  logic                frame_done;

  // Next-state: slot tracking, frame assembly, framing checks and output hold.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    frame_d      = frame_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    sync_err_d   = 1'b0;
    overrun_d    = 1'b0;
    err_inc      = 1'b0;
    frame_done   = 1'b0;

    if (dout_valid_q && out_ready) begin
      dout_valid_d = 1'b0;
    end

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            state_d    = RUN;
            frame_d    = '0;
            frame_d[0] = din;
            sel_d      = ONE_SEL;
          end
        end
        RUN: begin
          if (frame_sync && (sel_q != '0)) begin
            // Misplaced sync: drop the partial frame and realign on this bit.
            sync_err_d = 1'b1;
            err_inc    = 1'b1;
            frame_d    = '0;
            frame_d[0] = din;
            sel_d      = ONE_SEL;
          end else begin
            frame_d[sel_q] = din;
            if (sel_q == LAST_SEL) begin
              sel_d      = '0;
              frame_done = 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          sel_d   = '0;
        end
      endcase
    end

    if (frame_done) begin
      dout_d       = frame_d;
      dout_valid_d = 1'b1;
      overrun_d    = dout_valid_q && !out_ready;
    end
  end

  // State, slot counter, assembly and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      sel_q        <= '0;
      frame_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      frame_q      <= frame_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
      overrun_q    <= overrun_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk_i   (clk),
    .clr_ni  (rst_n),
    .inc_i   (err_inc),
    .count_o (err_cnt)
  );

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = (state_q == RUN);
  assign sync_err   = sync_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Bench for tdm_demux_rx: directed vector table, random stream against a
// behavioural frame model, async reset and error-counter saturation.
module tb_tdm_demux_rx;

  localparam int CH = 4;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [1:0] sel;
  logic [3:0] dout;
  logic       dout_valid;
  logic       out_ready;
  logic       locked;
  logic       sync_err;
  logic       overrun;
  logic [7:0] err_cnt;

  int tests_run = 0;
  int failures  = 0;

  tdm_demux_rx #(.CHANNELS(4), .SEL_W(2), .ERR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .sync_err   (sync_err),
    .overrun    (overrun),
    .err_cnt    (err_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: current slot, bits gathered so far, held frame.
  int       m_slot;
  bit       m_locked;
  bit       m_part[CH];
  bit [3:0] m_dout;
  bit       m_valid;
  bit       m_se;
  bit       m_ov;
  int       m_err;

  task automatic model_reset();
    m_slot = 0; m_locked = 0; m_dout = '0; m_valid = 0;
    m_se = 0; m_ov = 0; m_err = 0;
    for (int i = 0; i < CH; i++) m_part[i] = 0;
  endtask

  task automatic model_start_frame(input bit d);
    for (int i = 0; i < CH; i++) m_part[i] = 0;
    m_part[0] = d;
    m_slot = 1;
  endtask

  task automatic model_update(input bit dv, input bit d, input bit fs, input bit rdy);
    bit old_valid = m_valid;
    bit done = 0;
    m_se = 0;
    m_ov = 0;
    if (dv) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1;
          model_start_frame(d);
        end
      end else if (fs && m_slot != 0) begin
        m_se = 1;
        if (m_err < 255) m_err = m_err + 1;
        model_start_frame(d);
      end else begin
        m_part[m_slot] = d;
        m_slot = (m_slot + 1) % CH;
        if (m_slot == 0) done = 1;
      end
    end
    if (done) begin
      for (int i = 0; i < CH; i++) m_dout[i] = m_part[i];
      m_ov    = old_valid && !rdy;
      m_valid = 1;
    end else if (old_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  // Scoreboard check
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " sel"},        32'(sel),        32'(m_slot));
    check({tag, " dout"},       32'(dout),       32'(m_dout));
    check({tag, " dout_valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, " locked"},     32'(locked),     32'(m_locked));
    check({tag, " sync_err"},   32'(sync_err),   32'(m_se));
    check({tag, " overrun"},    32'(overrun),    32'(m_ov));
    check({tag, " err_cnt"},    32'(err_cnt),    32'(m_err));
  endtask

  // Driver: apply one cycle of inputs, advance model, compare after the edge.
  task automatic step(input logic dv, input logic d, input logic fs, input logic rdy,
                      input string tag);
    din_valid  = dv;
    din        = d;
    frame_sync = fs;
    out_ready  = rdy;
    @(posedge clk);
    model_update(dv, d, fs, rdy);
    #1;
    check_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sel"},        32'(sel),        0);
    check({tag, " dout"},       32'(dout),       0);
    check({tag, " dout_valid"}, 32'(dout_valid), 0);
    check({tag, " locked"},     32'(locked),     0);
    check({tag, " sync_err"},   32'(sync_err),   0);
    check({tag, " overrun"},    32'(overrun),    0);
    check({tag, " err_cnt"},    32'(err_cnt),    0);
  endtask

  // Directed vectors: inputs and hand-derived expected outputs after the edge.
  typedef struct {
    logic       dv, d, fs, rdy;
    logic [1:0] e_sel;
    logic [3:0] e_dout;
    logic       e_v, e_lk, e_se, e_ov;
    logic [7:0] e_err;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic dv, input logic d, input logic fs, input logic rdy,
                     input logic [1:0] s, input logic [3:0] o, input logic v,
                     input logic lk, input logic se, input logic ov, input logic [7:0] e);
    vec_t r;
    r.dv = dv; r.d = d; r.fs = fs; r.rdy = rdy;
    r.e_sel = s; r.e_dout = o; r.e_v = v; r.e_lk = lk;
    r.e_se = se; r.e_ov = ov; r.e_err = e;
    vec_q.push_back(r);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b0;
    model_reset();

    //   dv d fs rdy  sel dout  v lk se ov err
    // HUNT: beats without sync ignored, sync without valid ignored
    add(1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4'h0, 0, 0, 0, 0, 0);
    // Lock and assemble 1,0,1,1 (with a gap cycle) -> 4'b1101
    add(1, 1, 1, 1, 1, 4'h0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 2, 4'h0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 2, 4'h0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 3, 4'h0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 4'hD, 1, 1, 0, 0, 0);
    // Consumed; sync at slot 2 -> error, realign; frame 0,1,1,0 -> 4'b0110
    add(1, 0, 1, 1, 1, 4'hD, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 2, 4'hD, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 4'hD, 0, 1, 1, 0, 1);
    add(1, 1, 0, 1, 2, 4'hD, 0, 1, 0, 0, 1);
    add(1, 1, 0, 1, 3, 4'hD, 0, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 4'h6, 1, 1, 0, 0, 1);
    // Not ready across next frame 1,1,0,0 -> overwrite with overrun
    add(1, 1, 1, 0, 1, 4'h6, 1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 2, 4'h6, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 3, 4'h6, 1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 4'h3, 1, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 4'h3, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 4'h3, 0, 1, 0, 0, 1);
    // Frame 0,1,0,1 held, then completion with ready -> replaced, no overrun
    add(1, 0, 1, 0, 1, 4'h3, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 2, 4'h3, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 3, 4'h3, 0, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, 4'hA, 1, 1, 0, 0, 1);
    add(1, 1, 1, 0, 1, 4'hA, 1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 2, 4'hA, 1, 1, 0, 0, 1);
    add(1, 1, 0, 0, 3, 4'hA, 1, 1, 0, 0, 1);
    add(1, 1, 0, 1, 0, 4'hF, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 4'hF, 0, 1, 0, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("reset");

    // Table-driven directed vectors
    for (int i = 0; i < vec_q.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vec_q[i].dv, vec_q[i].d, vec_q[i].fs, vec_q[i].rdy, {t, " model"});
      check({t, " sel"},        32'(sel),        32'(vec_q[i].e_sel));
      check({t, " dout"},       32'(dout),       32'(vec_q[i].e_dout));
      check({t, " dout_valid"}, 32'(dout_valid), 32'(vec_q[i].e_v));
      check({t, " locked"},     32'(locked),     32'(vec_q[i].e_lk));
      check({t, " sync_err"},   32'(sync_err),   32'(vec_q[i].e_se));
      check({t, " overrun"},    32'(overrun),    32'(vec_q[i].e_ov));
      check({t, " err_cnt"},    32'(err_cnt),    32'(vec_q[i].e_err));
    end

    // Random stream against the model; sync mostly lands on slot 0
    for (int i = 0; i < 2000; i++) begin
      logic dv, d, fs, rdy;
      dv  = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom_range(0, 1));
      fs  = (m_slot == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(dv, d, fs, rdy, "rand");
    end

    // Reset mid-frame: outputs clear asynchronously, before any clock edge
    step(1, 1, 1, 1, "pre_rst_a");
    step(1, 0, 0, 1, "pre_rst_b");
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all_zero("post_rst");

    // Lock, then 260 back-to-back misplaced syncs saturate err_cnt
    step(1, 1, 1, 1, "sat_lock");
    for (int i = 0; i < 260; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1, 1, "sat");
    end
    check("sat err_cnt", 32'(err_cnt), 32'hFF);
    check("sat sync_err", 32'(sync_err), 1);
    step(1, 0, 0, 1, "sat_after");
    check("sat hold err_cnt", 32'(err_cnt), 32'hFF);
    check("sat pulse end", 32'(sync_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
